// File: rtl/serial_sub.sv
// serial_sub: bit-serial, LSB-first subtractor computing d = a - b with borrow-out.
// Operands load in parallel on an accepted start. The subtractor cell then runs
// one bit per clock for WIDTH clocks, and a one-cycle done pulse follows.
// Optional build macro SERIAL_SUB_ADD_MODE_EN adds a 'mode' input. With mode=1
// the cell behaves as a full adder and bo carries the carry-out.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   areg, breg, rreg;
  logic               borrow;
  logic [CNT_W-1:0]   count;
  logic               last_bit;
  logic [1:0]         cell_out;   // {borrow/carry out, result bit}
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic               mode_r;
`endif

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_cell(input logic a0, input logic b0, input logic bin);
    logic diff, bout;
    diff = a0 ^ b0 ^ bin;
    bout = (~a0 & b0) | (~(a0 ^ b0) & bin);
    return {bout, diff};
  endfunction

`ifdef SERIAL_SUB_ADD_MODE_EN
  // Full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] add_cell(input logic a0, input logic b0, input logic cin);
    logic sum, cout;
    sum  = a0 ^ b0 ^ cin;
    cout = (a0 & b0) | ((a0 ^ b0) & cin);
    return {cout, sum};
  endfunction
`endif

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // Evaluate the single arithmetic cell on the current LSBs and the borrow flop.
  always_comb begin
    cell_out = sub_cell(areg[0], breg[0], borrow);
`ifdef SERIAL_SUB_ADD_MODE_EN
    if (mode_r) cell_out = add_cell(areg[0], breg[0], borrow);
`endif
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT for WIDTH bits, one DONE cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, serial datapath, and result publication on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      areg   <= '0;
      breg   <= '0;
      rreg   <= '0;
      borrow <= 1'b0;
      count  <= '0;
      d      <= '0;
      bo     <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      mode_r <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            areg   <= a;
            breg   <= b;
            borrow <= 1'b0;
            count  <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            mode_r <= mode;
`endif
          end
        end
        SHIFT: begin
          areg   <= areg >> 1;
          breg   <= breg >> 1;
          rreg   <= {cell_out[0], rreg[WIDTH-1:1]};
          borrow <= cell_out[1];
          count  <= count + CNT_W'(1);
          // Only the finished word reaches d; partial results stay in rreg.
          if (last_bit) begin
            d  <= {cell_out[0], rreg[WIDTH-1:1]};
            bo <= cell_out[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and randomized checks of serial_sub at WIDTH=8 and WIDTH=2.
module tb_serial_sub;

  logic       clk;
  logic       rst;
  logic       start8, start2;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic       busy8, done8, bo8;
  logic       busy2, done2, bo2;
  logic [7:0] d8;
  logic [1:0] d2;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic       mode8, mode2;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode(mode8),
`endif
    .busy(busy8), .done(done8), .d(d8), .bo(bo8)
  );

  serial_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .mode(mode2),
`endif
    .busy(busy2), .done(done2), .d(d2), .bo(bo2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic. Result is {bo, d}.
  function automatic logic [8:0] ref8(input logic [7:0] av, input logic [7:0] bv, input logic add);
    int diff;
    if (add) return {1'b0, av} + {1'b0, bv};
    diff = int'(av) - int'(bv);
    return {(av < bv), 8'(diff)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete operation on the 8-bit instance, with handshake timing checks.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic add, input string tag);
    logic [8:0] exp;
    int lat, busy_n;
    bit got;
    exp = ref8(av, bv, add);
    a8 = av; b8 = bv; start8 = 1'b1;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode8 = add;
`endif
    tick();
    start8 = 1'b0;
    lat = 0; busy_n = 0; got = 1'b0;
    if (busy8) busy_n++;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done8) begin got = 1'b1; lat = i; break; end
      if (busy8) busy_n++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, "_d"}, 32'(d8), 32'(exp[7:0]));
    check({tag, "_bo"}, 32'(bo8), 32'(exp[8]));
    tick();
    check({tag, "_done_1cyc"}, 32'(done8), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy8), 32'd0);
  endtask

  // One operation on the 2-bit instance.
  task automatic do_op2(input logic [1:0] av, input logic [1:0] bv, input string tag);
    int lat;
    bit got;
    a2 = av; b2 = bv; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done2) begin got = 1'b1; lat = i; break; end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_d"}, 32'(d2), 32'((int'(av) - int'(bv)) & 3));
    check({tag, "_bo"}, 32'(bo2), 32'(av < bv));
    tick();
  endtask

  initial begin
    int lat, ndone, gap;
    bit got;
    logic [7:0] ra, rb;
    logic [3:0] iv;

    rst = 1'b1; start8 = 1'b0; start2 = 1'b0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    mode8 = 1'b0; mode2 = 1'b0;
`endif
    tick(); tick();
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_d", 32'(d8), 32'd0);
    check("reset_bo", 32'(bo8), 32'd0);
    rst = 1'b0;
    tick();

    // Basic subtraction cases.
    do_op8(8'h5A, 8'h3C, 1'b0, "sub_5a_3c");
    do_op8(8'h00, 8'h01, 1'b0, "sub_00_01");
    do_op8(8'h80, 8'h80, 1'b0, "sub_80_80");

    // A second start during SHIFT must be ignored.
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    got = 1'b0; lat = 0;
    for (int i = 4; i <= 40; i++) begin
      tick();
      if (done8) begin got = 1'b1; lat = i; break; end
    end
    check("ign_done_seen", 32'(got), 32'd1);
    check("ign_latency", 32'(lat), 32'd8);
    check("ign_d", 32'(d8), 32'h0F);
    check("ign_bo", 32'(bo8), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8) ndone++;
    end
    check("ign_no_extra_done", 32'(ndone), 32'd0);
    check("ign_hold_d", 32'(d8), 32'h0F);
    check("ign_hold_bo", 32'(bo8), 32'd0);

    // Reset in the middle of an operation abandons it.
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy8), 32'd0);
    check("rst_mid_done", 32'(done8), 32'd0);
    check("rst_mid_d", 32'(d8), 32'd0);
    check("rst_mid_bo", 32'(bo8), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) ndone++;
    end
    check("rst_mid_no_done", 32'(ndone), 32'd0);
    do_op8(8'h09, 8'h0A, 1'b0, "sub_09_0a");

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done8) begin got = 1'b1; break; end
    end
    check("hold_first_done", 32'(got), 32'd1);
    got = 1'b0; gap = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done8) begin got = 1'b1; gap = i; break; end
    end
    start8 = 1'b0;
    check("hold_second_done", 32'(got), 32'd1);
    check("hold_gap", 32'(gap), 32'd10);
    check("hold_d", 32'(d8), 32'hFF);
    check("hold_bo", 32'(bo8), 32'd1);
    tick(); tick();

    // Randomized subtraction against the arithmetic reference.
    for (int k = 0; k < 12; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op8(ra, rb, 1'b0, $sformatf("rnd%0d", k));
    end

    // Exhaustive 2-bit subtraction.
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      do_op2(iv[3:2], iv[1:0], $sformatf("w2_%0d", i));
    end

`ifdef SERIAL_SUB_ADD_MODE_EN
    do_op8(8'hFF, 8'h01, 1'b1, "add_ff_01");
    do_op8(8'h12, 8'h34, 1'b1, "add_12_34");
    for (int k = 0; k < 6; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op8(ra, rb, 1'($urandom), $sformatf("rndm%0d", k));
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
